register_serializer: RTL
========================

Name: register_serializer

Overview:
- Parallel-in, serial-out transmitter: the read-side counterpart to the team's parallel-load registers.
- Captures an N-bit word from a register's Q output on a load strobe.
- Shifts the word out MSB-first, one bit per clock, under a valid/ready handshake.
- Signals completion with a one-cycle done pulse; used to stream register contents (e.g. AC, DR) to a serial sink or debug port.

Parameters:
- N, 16, data word width in bits (N >= 2).

Ports:
- clk  input  1  system clock, all state updates on posedge.
- clear_n  input  1  synchronous active-low reset, sampled on posedge clk.
- load  input  1  capture request; honoured only when busy=0.
- data  input  N  word to transmit; sampled only on the accepting edge.
- sout_ready  input  1  sink ready; a bit is consumed on an edge where sout_valid=1 and sout_ready=1.
- sout  output  1  current serial bit (registered).
- sout_valid  output  1  sout holds a valid bit (registered).
- busy  output  1  transfer in progress; load ignored while 1.
- done  output  1  one-cycle pulse after the final bit is consumed.
- bits_left  output  $clog2(N+2)  bits not yet consumed, including the bit currently on sout.

Behaviour:
- Reset: clear_n=0 at a posedge forces the following values, regardless of other inputs, including mid-transfer:
  - state=IDLE; shift register=0.
  - sout=0, sout_valid=0, busy=0, done=0, bits_left=0.
  - No done pulse is produced for an aborted transfer.
- States: IDLE and SHIFT. All outputs are registered.
- IDLE to SHIFT: on an edge with load=1, the word is captured.
  - Next cycle: sout=data[N-1], sout_valid=1, busy=1, bits_left=L.
  - L=N without PARITY_EN; L=N+1 with it.
- SHIFT, sout_ready=0 (stall): sout, sout_valid and bits_left hold; there is no timeout.
- SHIFT, sout_ready=1 and bits_left>1 (advance): the shift register moves left by one, sout takes the next lower bit, and bits_left decrements.
- SHIFT, sout_ready=1 and bits_left=1 (final bit consumed): the next cycle has state=IDLE, sout_valid=0, busy=0, done=1 for exactly one cycle, sout=0 and bits_left=0.
- Back-to-back transfers: load may be asserted in the done cycle, because the block is already IDLE.
  - With sout_ready held at 1, a new word's MSB appears two cycles after the previous final bit.
  - This gives a one-cycle bubble between words.
- load while busy=1 is ignored and has no side effects.
- Changes on data after the accepting edge have no effect.
- Latency with sout_ready held at 1, for a load accepted at edge k:
  - Bits are presented in cycles k+1 through k+L.
  - done is 1 in cycle k+L+1.
- data is a don't-care except on the accepting edge.

Optional Feature:
- Macro: REGISTER_SERIALIZER_PARITY_EN.
- Defined: after the N data bits, one extra bit is transmitted, equal to the XOR of all N captured bits (even parity). L=N+1, and bits_left starts at N+1. The parity bit has the same handshake and stall rules as a data bit.
- Undefined: no parity logic is built, L=N, and the final bit is data[0].

Test Plan:
- Basic transfer: N=16, sout_ready=1, load=1 for one cycle with data=16'hA5C3.
  - Required: sout sequence 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 over cycles k+1..k+16, with sout_valid=1 and busy=1 throughout.
  - Required: done=1 only in cycle k+17; bits_left runs 16 down to 1, then 0.
- Stall: data=16'h8001, sout_ready=0 during cycles k+3..k+6.
  - Required: sout, sout_valid and bits_left (=14) hold constant during the stall.
  - Required: the transfer completes 4 cycles late, with done in cycle k+21.
- Ignored load: during a transfer of 16'hFFFF, pulse load=1 with data=16'h0000.
  - Required: all 16 bits are 1, exactly one done pulse occurs, and no second transfer starts.
- Reset mid-transfer: clear_n=0 at the edge after the 5th bit is consumed.
  - Required: next cycle sout=0, sout_valid=0, busy=0, done=0, bits_left=0, and no done pulse follows.
  - Required: a following load of 16'h1234 transmits correctly.
- Back-to-back: load 16'h00FF, then assert load with 16'hFF00 in the done cycle, sout_ready=1.
  - Required: exactly one invalid cycle between the two words, and the second word is bit-exact.
- Parity (macro defined): data=16'h0007.
  - Required: 17 valid bits, the 17th = 1; bits_left starts at 17; done in cycle k+18.
  - Required: data=16'h0003 gives a 17th bit = 0.

Source files
------------

// File: rtl/register_serializer.sv
// register_serializer: parallel-in, serial-out transmitter.
// Captures an N-bit word on load while idle, then shifts it out MSB-first,
// one bit per accepted valid/ready handshake. A one-cycle done pulse marks
// the cycle after the final bit is consumed.
// Optional feature macro: REGISTER_SERIALIZER_PARITY_EN appends an even
// parity bit (XOR of the captured word) after the N data bits.
module register_serializer #(
    parameter int N = 16
) (
    input  logic                     clk,
    input  logic                     clear_n,
    input  logic                     load,
    input  logic [N-1:0]             data,
    input  logic                     sout_ready,
    output logic                     sout,
    output logic                     sout_valid,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(N+2)-1:0]   bits_left
);

    localparam int BW = $clog2(N+2);
`ifdef REGISTER_SERIALIZER_PARITY_EN
    localparam int L = N + 1;
`else
    localparam int L = N;
`endif
    localparam logic [BW-1:0] L_CNT = BW'(L);
    localparam logic [BW-1:0] ONE   = BW'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state;
    // Bits still waiting behind the one currently on sout, MSB next.
    logic [L-2:0]    shreg;
    logic [L-1:0]    load_word;

    // Full frame to transmit: data word, optionally followed by its parity.
    always_comb begin
`ifdef REGISTER_SERIALIZER_PARITY_EN
        load_word = {data, ^data};
`else
        load_word = data;
`endif
    end

    // Control FSM with registered outputs; the MSB of the frame goes straight
    // to sout on capture so the first bit is valid the cycle after load.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state      <= IDLE;
            shreg      <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bits_left  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        state      <= SHIFT;
                        sout       <= load_word[L-1];
                        shreg      <= load_word[L-2:0];
                        sout_valid <= 1'b1;
                        busy       <= 1'b1;
                        bits_left  <= L_CNT;
                    end
                end
                SHIFT: begin
                    if (sout_ready) begin
                        if (bits_left == ONE) begin
                            // Final bit consumed: return to idle and pulse done.
                            state      <= IDLE;
                            shreg      <= '0;
                            sout       <= 1'b0;
                            sout_valid <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            bits_left  <= '0;
                        end else begin
                            sout      <= shreg[L-2];
                            shreg     <= shreg << 1;
                            bits_left <= bits_left - ONE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
